// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction-fetch stage with PC, IF/ID register, redirect and fault handling
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc_address,
  input  logic [31:0] instruction,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc_plus4,
  output logic        misaligned_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic {RUN, FAULT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
  logic        fault_q, fault_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_pc_q       <= 32'h0;
      if_instr_q    <= NOP_INSTR;
      if_pc_plus4_q <= 32'h0;
      fault_q       <= 1'b0;
      fetch_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_pc_q       <= if_pc_d;
      if_instr_q    <= if_instr_d;
      if_pc_plus4_q <= if_pc_plus4_d;
      fault_q       <= fault_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_pc_d       = if_pc_q;
    if_instr_d    = if_instr_q;
    if_pc_plus4_d = if_pc_plus4_q;
    fault_d       = fault_q;
    fetch_count_d = fetch_count_q;

    // Redirect wins over both the fault hold and decode back-pressure.
    if (redirect_valid) begin
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
      pc_d       = redirect_target;
      if (redirect_target[1:0] == 2'b00) begin
        state_d = RUN;
        fault_d = 1'b0;
      end else begin
        state_d = FAULT;
        fault_d = 1'b1;
      end
    end else if (state_q == RUN && !stall) begin
      if_valid_d    = 1'b1;
      if_pc_d       = pc_q;
      if_instr_d    = instruction;
      if_pc_plus4_d = pc_plus4;
      pc_d          = pc_plus4;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  assign pc_address       = pc_q;
  assign if_valid         = if_valid_q;
  assign if_pc            = if_pc_q;
  assign if_instruction   = if_instr_q;
  assign if_pc_plus4      = if_pc_plus4_q;
  assign misaligned_fault = fault_q;
  assign fetch_count      = fetch_count_q;

endmodule
